// File: rtl/register_file_pkg.sv
// Shared defaults and typedefs for the register file and its pending-writeback scoreboard.
package register_file_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;
endpackage

// File: rtl/register_file_scoreboard.sv
// Pending-writeback scoreboard: one bit per register, set beats clear, busy flags report post-edge state.
module register_file_scoreboard
  import register_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic              o_busy1,
  output logic              o_busy2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;

  // Clear first so a coincident set on the same register wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr) w_pend_nxt[i_clr_addr] = 1'b0;
    if (i_set) w_pend_nxt[i_set_addr] = 1'b1;
    if (ZERO_REG) w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend  <= '0;
      o_busy1 <= 1'b0;
      o_busy2 <= 1'b0;
    end else begin
      r_pend  <= w_pend_nxt;
      o_busy1 <= w_pend_nxt[i_rd_addr1];
      o_busy2 <= w_pend_nxt[i_rd_addr2];
    end
  end
endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file with registered reads, write-through bypass and pending scoreboard.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              busy1,
  output logic              busy2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_en;
  logic              w_byp1;
  logic              w_byp2;

  // Writes to a hardwired zero register are dropped, which also keeps it out of the bypass.
  assign w_wr_en = reg_write && !(ZERO_REG && (wr_addr == '0));
  assign w_byp1  = w_wr_en && (wr_addr == rd_addr1);
  assign w_byp2  = w_wr_en && (wr_addr == rd_addr2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      if (w_wr_en) r_mem[wr_addr] <= wr_data;
      rd_data1 <= w_byp1 ? wr_data : r_mem[rd_addr1];
      rd_data2 <= w_byp2 ? wr_data : r_mem[rd_addr2];
    end
  end

  register_file_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_set     (pend_set),
    .i_set_addr(pend_addr),
    .i_clr     (reg_write),
    .i_clr_addr(wr_addr),
    .i_rd_addr1(rd_addr1),
    .i_rd_addr2(rd_addr2),
    .o_busy1   (busy1),
    .o_busy2   (busy2)
  );
endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench for register_file: driver queues expected responses, a monitor pops and compares.
module tb_register_file;
  import register_file_pkg::*;

  logic  clock = 1'b0;
  logic  reset;
  logic  reg_write;
  addr_t wr_addr;
  data_t wr_data;
  addr_t rd_addr1;
  addr_t rd_addr2;
  data_t rd_data1;
  data_t rd_data2;
  logic  pend_set;
  addr_t pend_addr;
  logic  busy1;
  logic  busy2;

  register_file dut (
    .clock    (clock),
    .reset    (reset),
    .reg_write(reg_write),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .pend_set (pend_set),
    .pend_addr(pend_addr),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] tag;
    data_t       d1;
    data_t       d2;
    logic        b1;
    logic        b2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic chk_in = 1'b0;
  logic vld_p0 = 1'b0;
  logic imm_chk = 1'b0;

  // Marks which edges produce an output the monitor must check.
  always @(posedge clock) vld_p0 <= chk_in;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (vld_p0 || imm_chk) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL noexp: output presented with no expected entry");
        end else begin
          e = exp_q.pop_front();
          if (rd_data1 !== e.d1 || rd_data2 !== e.d2 || busy1 !== e.b1 || busy2 !== e.b2) begin
            errors++;
            $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b expected d1=%h d2=%h b1=%b b2=%b",
                     e.tag, rd_data1, rd_data2, busy1, busy2, e.d1, e.d2, e.b1, e.b2);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [63:0] tag, input data_t d1, input data_t d2,
                      input logic b1, input logic b2);
    exp_t e;
    e.tag = tag; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic we, input addr_t wa, input data_t wd,
                     input logic ps, input addr_t pa, input addr_t ra1, input addr_t ra2,
                     input logic chk, input data_t d1, input data_t d2,
                     input logic b1, input logic b2, input logic [63:0] tag);
    reg_write = we; wr_addr = wa; wr_data = wd;
    pend_set = ps; pend_addr = pa; rd_addr1 = ra1; rd_addr2 = ra2;
    if (chk) push(tag, d1, d2, b1, b2);
    chk_in = chk;
    @(posedge clock);
    #1;
  endtask

  initial begin : driver
    reset = 1'b1; reg_write = 1'b0; wr_addr = '0; wr_data = '0;
    pend_set = 1'b0; pend_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
    #2;
    push("rst0", 16'h0000, 16'h0000, 1'b0, 1'b0);
    imm_chk = 1'b1;
    @(negedge clock); #1; imm_chk = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Fresh reset: every register reads zero, nothing busy
    for (int i = 1; i < 8; i++)
      cyc(0, 0, 0, 0, 0, addr_t'(i), addr_t'(8 - i), 1, 16'h0000, 16'h0000, 0, 0, "rstrd");

    cyc(1, 5, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 0, 0, 5, 0, 1, 16'hBEEF, 16'h0000, 0, 0, "wrrd5");
    cyc(1, 3, 16'h1234, 0, 0, 3, 3, 1, 16'h1234, 16'h1234, 0, 0, "bypass3");
    cyc(1, 6, 16'h7777, 0, 0, 5, 6, 1, 16'hBEEF, 16'h7777, 0, 0, "byp6old5");
    cyc(1, 7, 16'h8001, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 0, 0, 7, 3, 1, 16'h8001, 16'h1234, 0, 0, "fullw7");

    // Register 0 ignores writes, pend_set and bypass
    cyc(1, 0, 16'hFFFF, 1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, "zerobyp");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, "zerord");

    cyc(0, 0, 0, 1, 2, 2, 1, 1, 16'h0000, 16'h0000, 1, 0, "pend2");
    cyc(1, 2, 16'h00AA, 0, 0, 2, 2, 1, 16'h00AA, 16'h00AA, 0, 0, "clr2");
    cyc(0, 0, 0, 0, 0, 2, 5, 1, 16'h00AA, 16'hBEEF, 0, 0, "rd2");
    cyc(1, 2, 16'h0BB0, 1, 2, 2, 2, 1, 16'h0BB0, 16'h0BB0, 1, 1, "setwins");
    cyc(0, 0, 0, 0, 0, 2, 3, 1, 16'h0BB0, 16'h1234, 1, 0, "hold2");

    // Mid-operation asynchronous reset
    cyc(1, 4, 16'h5555, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 1, 4, 4, 2, 1, 16'h5555, 16'h0BB0, 1, 1, "pre_rst");
    cyc(0, 0, 0, 0, 0, 4, 2, 0, 0, 0, 0, 0, "");
    push("async", 16'h0000, 16'h0000, 1'b0, 1'b0);
    imm_chk = 1'b1;
    #2 reset = 1'b1;
    @(negedge clock); #1; imm_chk = 1'b0;
    reg_write = 1'b1; wr_addr = 1; wr_data = 16'h1111;
    @(posedge clock); #1;
    reset = 1'b0;

    // First edge after deassertion behaves normally
    cyc(1, 1, 16'h2222, 1, 1, 1, 0, 1, 16'h2222, 16'h0000, 1, 0, "postrst");
    cyc(0, 0, 0, 0, 0, 4, 2, 1, 16'h0000, 16'h0000, 0, 0, "r4clear");
    cyc(0, 0, 0, 0, 0, 1, 5, 1, 16'h2222, 16'h0000, 1, 0, "r1keep");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
